// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches and buffers {instr, pc} for decode, with jump flush.
// Optional FETCH_QUEUE_STATS_EN adds a saturating flush_count output.
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [7:0] imem_addr,
    output logic       imem_rd,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic       out_valid,
    output logic [7:0] out_instr,
    output logic [7:0] out_pc,
    input  logic       out_ready,
    input  logic       jump,
    input  logic [7:0] jump_addr
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [7:0] flush_count
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];
    localparam logic [PW:0] CNT_LAST = CNT_FULL - 1'b1;

    typedef enum logic [1:0] {
        RUN,
        FULL,
        DISCARD
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_started;
    logic [7:0]    r_fetch_pc;
    logic [7:0]    r_hold_addr;
    logic [PW:0]   r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [7:0]    r_instr_mem [DEPTH];
    logic [7:0]    r_pc_mem    [DEPTH];

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full    = (r_count == CNT_FULL);
    assign out_valid = (r_count != '0);
    assign out_instr = r_instr_mem[r_rd_ptr];
    assign out_pc    = r_pc_mem[r_rd_ptr];

    assign w_pop  = out_valid && out_ready && !jump;
    assign w_push = (r_state == RUN) && imem_rd && imem_ack && !jump && (!w_full || w_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                // A request still in flight at jump time must be drained before refetching.
                if (jump) begin
                    w_state_nxt = (imem_rd && !imem_ack) ? DISCARD : RUN;
                end else if (w_push && !w_pop && (r_count == CNT_LAST)) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (jump || !w_full) begin
                    w_state_nxt = RUN;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        imem_rd   = r_started && (r_state != FULL);
        imem_addr = (r_state == DISCARD) ? r_hold_addr : r_fetch_pc;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_started   <= 1'b0;
            r_fetch_pc  <= '0;
            r_hold_addr <= '0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_instr_mem[i] <= '0;
                r_pc_mem[i]    <= '0;
            end
        end else begin
            r_started <= 1'b1;
            if (jump) begin
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_fetch_pc <= jump_addr;
                if (r_state == RUN) begin
                    r_hold_addr <= r_fetch_pc;
                end
            end else begin
                if (w_push) begin
                    r_instr_mem[r_wr_ptr] <= imem_data;
                    r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
                    r_wr_ptr              <= r_wr_ptr + 1'b1;
                    r_fetch_pc            <= r_fetch_pc + 8'd1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [7:0] r_flush_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_count <= '0;
        end else if (jump && (r_flush_count != 8'hFF)) begin
            r_flush_count <= r_flush_count + 8'd1;
        end
    end

    assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4); memory answers data = addr ^ 0xA5.
module tb_fetch_queue;

    logic       clock;
    logic       reset_n;
    logic [7:0] imem_addr;
    logic       imem_rd;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       out_valid;
    logic [7:0] out_instr;
    logic [7:0] out_pc;
    logic       out_ready;
    logic       jump;
    logic [7:0] jump_addr;
`ifdef FETCH_QUEUE_STATS_EN
    logic [7:0] flush_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .imem_addr (imem_addr),
        .imem_rd   (imem_rd),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .jump      (jump),
        .jump_addr (jump_addr)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .flush_count (flush_count)
`endif
    );

    assign imem_data = imem_addr ^ 8'hA5;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves the DUT one cycle past reset release, so imem_rd is already up at 0x00.
    task automatic do_reset();
        reset_n   = 1'b0;
        jump      = 1'b0;
        jump_addr = 8'h00;
        imem_ack  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        reset_n   = 1'b0;
        jump      = 1'b0;
        jump_addr = 8'h00;
        imem_ack  = 1'b0;
        out_ready = 1'b0;
        step();
        step();

        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_instr", out_instr, 8'h00);
        check_eq("rst_pc",    out_pc,    8'h00);
        check_eq("rst_rd",    imem_rd,   0);
        check_eq("rst_addr",  imem_addr, 8'h00);
`ifdef FETCH_QUEUE_STATS_EN
        check_eq("rst_flush", flush_count, 8'h00);
`endif

        reset_n = 1'b1;
        check_eq("rel_rd_low", imem_rd, 0);
        step();
        check_eq("first_rd",   imem_rd,   1);
        check_eq("first_addr", imem_addr, 8'h00);

        // Streaming: one instruction per cycle.
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("str_valid", out_valid, 1);
            check_eq("str_pc",    out_pc,    i);
            check_eq("str_instr", out_instr, i ^ 8'hA5);
        end

        // Fill to FULL, single pop, fetch resumes at 0x04.
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b0;
        repeat (4) step();
        check_eq("full_valid", out_valid, 1);
        check_eq("full_rd",    imem_rd,   0);
        check_eq("full_pc",    out_pc,    8'h00);
        check_eq("full_addr",  imem_addr, 8'h04);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("pop_pc", out_pc, 8'h01);
        for (int k = 0; k < 5; k++) begin
            if (imem_rd) break;
            step();
        end
        check_eq("resume_rd",   imem_rd,   1);
        check_eq("resume_addr", imem_addr, 8'h04);
        step();
        check_eq("resume_head", out_pc, 8'h01);

        // Jump with request to 0x03 pending; ack arrives two cycles later.
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        check_eq("pre_jmp_addr", imem_addr, 8'h03);
        imem_ack  = 1'b0;
        jump      = 1'b1;
        jump_addr = 8'h40;
        step();
        jump = 1'b0;
        check_eq("dis_valid", out_valid, 0);
        check_eq("dis_rd",    imem_rd,   1);
        check_eq("dis_addr",  imem_addr, 8'h03);
        step();
        check_eq("dis_hold",  imem_addr, 8'h03);
        imem_ack = 1'b1;
        step();
        check_eq("dis_drop_valid", out_valid, 0);
        check_eq("dis_new_addr",   imem_addr, 8'h40);
        step();
        check_eq("jmp_valid", out_valid, 1);
        check_eq("jmp_pc",    out_pc,    8'h40);
        check_eq("jmp_instr", out_instr, 8'hE5);

        // Jump, pop and ack in the same cycle with the queue half full.
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b0;
        repeat (2) step();
        check_eq("half_pc", out_pc, 8'h00);
        jump      = 1'b1;
        jump_addr = 8'h80;
        out_ready = 1'b1;
        step();
        jump = 1'b0;
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_addr",  imem_addr, 8'h80);
        check_eq("flush_rd",    imem_rd,   1);
        step();
        check_eq("post_valid", out_valid, 1);
        check_eq("post_pc",    out_pc,    8'h80);
        check_eq("post_instr", out_instr, 8'h25);

        // Address wrap through 0xFF.
        do_reset();
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        jump      = 1'b1;
        jump_addr = 8'hFE;
        step();
        jump = 1'b0;
        check_eq("wrap_addr", imem_addr, 8'hFE);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("wrap_pc",    out_pc,    (8'hFE + i) & 8'hFF);
            check_eq("wrap_instr", out_instr, ((8'hFE + i) & 8'hFF) ^ 8'hA5);
        end

`ifdef FETCH_QUEUE_STATS_EN
        do_reset();
        imem_ack = 1'b1;
        jump     = 1'b1;
        repeat (300) step();
        jump = 1'b0;
        check_eq("flush_sat", flush_count, 8'hFF);
        do_reset();
        check_eq("flush_clr", flush_count, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; legal values 2, 4 or 8.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port imem_addr  output  8  fetch address to instruction memory.
REQ-005 SHALL have port imem_rd  output  1  fetch request.
REQ-006 SHALL have port imem_ack  input  1  memory response strobe; imem_data is valid in the same cycle.
REQ-007 SHALL have port imem_data  input  8  fetched instruction.
REQ-008 SHALL have port out_valid  output  1  queue head is valid, for decode.
REQ-009 SHALL have port out_instr  output  8  instruction at the queue head.
REQ-010 SHALL have port out_pc  output  8  address of the head instruction.
REQ-011 SHALL have port out_ready  input  1  decode consumes the head this cycle.
REQ-012 SHALL have port jump  input  1  redirect request from the control unit.
REQ-013 SHALL have port jump_addr  input  8  redirect target.

Function
REQ-014 SHALL be a DEPTH-entry FIFO; each entry holds {instr, pc}; out_* SHALL show the head entry directly from storage, with no added latency.
REQ-015 SHALL hold fetch_pc (8 bit), which drives imem_addr; fetch_pc SHALL increment by 1 per accepted ack and wrap 0xFF->0x00.
REQ-016 SHALL implement FSM states RUN, FULL and DISCARD.
REQ-017 In RUN: imem_rd=1; on imem_ack, push {imem_data, fetch_pc}; go to FULL when the push makes the queue full with no pop in the same cycle.
REQ-018 In FULL: imem_rd=0; return to RUN in the cycle after the queue has at least one free entry.
REQ-019 Once raised, imem_rd and imem_addr SHALL stay stable until imem_ack, except under REQ-021.
REQ-020 Pop SHALL occur when out_valid && out_ready && !jump; push and pop in the same cycle SHALL leave the count unchanged.
REQ-021 On jump: flush all entries (out_valid=0 next cycle) and load fetch_pc=jump_addr.
REQ-021a After the flush, enter RUN if no request is outstanding or imem_ack is high in the same cycle; otherwise enter DISCARD.
REQ-022 In DISCARD: keep imem_rd=1 at the old address; on imem_ack, drop the data and enter RUN, which issues from jump_addr.
REQ-023 Jump SHALL take priority over a same-cycle push and a same-cycle pop; a jump while in DISCARD SHALL only update fetch_pc.
REQ-024 SHALL never push when full and never pop when empty; count SHALL stay within 0..DEPTH.

Reset
REQ-025 While reset_n=0: state=RUN, fetch_pc=0x00, count=0, rd/wr pointers=0, out_valid=0, out_instr=0x00, out_pc=0x00, imem_rd=0.
REQ-026 imem_rd SHALL first assert in the cycle after reset_n deasserts, with imem_addr=0x00.
REQ-027 Reset asserted mid-request SHALL abandon that request; any later imem_ack for it SHALL be treated as a response to the new fetch at 0x00.

Configuration
REQ-028 With FETCH_QUEUE_STATS_EN defined: add output flush_count (8 bit) that increments on each jump, saturates at 0xFF and resets to 0x00.
REQ-029 Without FETCH_QUEUE_STATS_EN: the flush_count port and its logic SHALL be absent, with function otherwise identical.

Verification
REQ-030 Reset, then imem_ack every cycle with data=addr^0xA5 and out_ready=1 -> out_pc sequence 00,01,02..., each out_instr = pc^0xA5, one instruction per cycle.
REQ-031 DEPTH=4, out_ready=0, ack every cycle -> 4 pushes, out_valid=1, imem_rd=0, state FULL; out_ready pulses once -> pop of pc 00, fetch of addr 04 resumes.
REQ-032 jump with jump_addr=0x40 while a request to 0x03 is pending without ack, ack 2 cycles later -> that data is discarded, next imem_addr=0x40, out_pc=0x40 is the first valid output after the jump.
REQ-033 jump, out_ready and imem_ack in the same cycle with the queue half full -> queue empty next cycle, no entry from before the jump ever seen, fetch_pc=jump_addr.
REQ-034 jump_addr=0xFE, continuous acks -> out_pc FE, FF, 00, 01 (wrap).
REQ-035 FETCH_QUEUE_STATS_EN defined, 300 jump pulses -> flush_count=0xFF; after reset_n pulse -> 0x00.
